// File: rtl/uart_rx_core.sv
// ============================================================================
// Module   : uart_rx_core
// Purpose  : UART receive engine. Oversamples the serial line, takes a 2-of-3
//            majority vote around the middle of every bit and deserialises a
//            frame of DATA_WIDTH data bits, optional even/odd parity and one
//            or two stop bits. Good frames load P_DATA with a one-cycle
//            Data_Valid strobe; bad frames raise par_err / stp_err strobes,
//            and a start bit that does not survive its vote raises
//            strt_glitch.
// Ports    : clk         - oversampling clock
//            rst_n       - asynchronous active-low reset
//            RX_IN       - serial line (idle high), already synchronised
//            Par_En      - frame carries a parity bit
//            Par_Typ     - 0 even parity, 1 odd parity
//            Stop2       - 1 two stop bits, 0 one stop bit
//            Prescale    - clk cycles per bit (even, >= 8)
//            P_DATA      - last good word, LSB = first data bit on the line
//            Data_Valid  - one-cycle strobe when P_DATA is loaded
//            par_err     - one-cycle strobe on parity mismatch
//            stp_err     - one-cycle strobe on a stop bit voted low
//            strt_glitch - one-cycle strobe on a false start bit
//            busy        - high whenever a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    input  logic                  Stop2,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
);

    localparam int c_BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [c_BIT_CNT_W-1:0] c_BITS_LAST = c_BIT_CNT_W'(DATA_WIDTH);
    localparam logic [PRESCALE_W-1:0]  c_EC_ONE    = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0]  c_EC_TWO    = PRESCALE_W'(2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Frame configuration, frozen for the duration of a frame
    logic [PRESCALE_W-1:0]  r_prescale;
    logic                   r_par_en;
    logic                   r_par_typ;
    logic                   r_stop2;

    logic [PRESCALE_W-1:0]  r_edge_cnt;
    logic [2:0]             r_smp;
    logic [c_BIT_CNT_W-1:0] r_bit_cnt;
    logic                   r_stop_cnt;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic                   r_xor;
    logic                   r_par_fail;
    logic                   r_stp_fail;
    logic                   r_armed;

    logic [DATA_WIDTH-1:0]  r_p_data;
    logic                   r_data_valid;
    logic                   r_par_err;
    logic                   r_stp_err;
    logic                   r_glitch;

    logic [PRESCALE_W-1:0]  w_half;
    logic                   w_is_dec;
    logic                   w_bit_end;
    logic                   w_vote;
    logic                   w_start;
    logic                   w_stop_bad;
    logic                   w_dv_nxt;
    logic                   w_perr_nxt;
    logic                   w_serr_nxt;
    logic                   w_glitch_nxt;

    // ------------------------------------------------------------------
    // Bit timing: the decision edge sits two cycles past mid-bit so the
    // third sample (mid+1) is already registered when the vote is used.
    // Prescale >= 8 guarantees the decision edge precedes the bit end.
    // ------------------------------------------------------------------
    assign w_half    = r_prescale >> 1;
    assign w_is_dec  = (r_edge_cnt == (w_half + c_EC_TWO));
    assign w_bit_end = (r_edge_cnt == (r_prescale - c_EC_ONE));
    assign w_vote    = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) |
                       (r_smp[1] & r_smp[2]);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_stop_bad   = 1'b0;
        w_dv_nxt     = 1'b0;
        w_perr_nxt   = 1'b0;
        w_serr_nxt   = 1'b0;
        w_glitch_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                // The cycle that sees the low level is edge 0 of the start bit
                if (r_armed && !RX_IN) begin
                    w_state_nxt = S_START;
                    w_start     = 1'b1;
                end
            end

            S_START: begin
                if (w_is_dec && w_vote) begin
                    w_state_nxt  = S_IDLE;
                    w_glitch_nxt = 1'b1;
                end else if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end

            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == c_BITS_LAST)) begin
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end

            S_STOP: begin
                // Frame resolves at the last stop bit's decision edge; the
                // rest of that stop bit is absorbed by IDLE.
                if (w_is_dec && (r_stop_cnt == r_stop2)) begin
                    w_state_nxt = S_IDLE;
                    w_stop_bad  = r_stp_fail | ~w_vote;
                    if (!r_par_fail && !w_stop_bad) begin
                        w_dv_nxt = 1'b1;
                    end else begin
                        w_perr_nxt = r_par_fail;
                        w_serr_nxt = w_stop_bad;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: edge counter, samplers, shift register and frame flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_stop2    <= 1'b0;
            r_edge_cnt <= '0;
            r_smp      <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_xor      <= 1'b0;
            r_par_fail <= 1'b0;
            r_stp_fail <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            // Configuration is only sampled when a frame starts
            if (w_start) begin
                r_prescale <= Prescale;
                r_par_en   <= Par_En;
                r_par_typ  <= Par_Typ;
                r_stop2    <= Stop2;
            end

            // IDLE cycle with the low level counts as edge 0, so the
            // first START cycle is edge 1.
            if (w_start) begin
                r_edge_cnt <= c_EC_ONE;
            end else if (w_state_nxt == S_IDLE) begin
                r_edge_cnt <= '0;
            end else if (w_bit_end) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + c_EC_ONE;
            end

            if (r_state != S_IDLE) begin
                if (r_edge_cnt == (w_half - c_EC_ONE)) begin
                    r_smp[0] <= RX_IN;
                end
                if (r_edge_cnt == w_half) begin
                    r_smp[1] <= RX_IN;
                end
                if (r_edge_cnt == (w_half + c_EC_ONE)) begin
                    r_smp[2] <= RX_IN;
                end
            end

            if (w_start) begin
                r_bit_cnt  <= '0;
                r_stop_cnt <= 1'b0;
                r_xor      <= 1'b0;
                r_par_fail <= 1'b0;
                r_stp_fail <= 1'b0;
            end else begin
                if ((r_state == S_DATA) && w_is_dec) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    r_shift   <= {w_vote, r_shift[DATA_WIDTH-1:1]};
                    r_xor     <= r_xor ^ w_vote;
                end
                if ((r_state == S_PARITY) && w_is_dec) begin
                    r_par_fail <= (w_vote != (r_xor ^ r_par_typ));
                end
                if ((r_state == S_STOP) && w_is_dec && !w_vote) begin
                    r_stp_fail <= 1'b1;
                end
                // Only the first of two stop bits ever reaches its bit end
                if ((r_state == S_STOP) && w_bit_end) begin
                    r_stop_cnt <= 1'b1;
                end
            end

            // A stop error disarms the receiver so a held-low line (break)
            // cannot be mistaken for a new start bit.
            if (w_serr_nxt) begin
                r_armed <= 1'b0;
            end else if (RX_IN) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            r_glitch     <= 1'b0;
        end else begin
            r_data_valid <= w_dv_nxt;
            r_par_err    <= w_perr_nxt;
            r_stp_err    <= w_serr_nxt;
            r_glitch     <= w_glitch_nxt;
            if (w_dv_nxt) begin
                r_p_data <= r_shift;
            end
        end
    end

    assign P_DATA      = r_p_data;
    assign Data_Valid  = r_data_valid;
    assign par_err     = r_par_err;
    assign stp_err     = r_stp_err;
    assign strt_glitch = r_glitch;
    assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module   : tb_uart_rx_core
// Purpose  : Directed self-checking bench for uart_rx_core. One instance is
//            built with 8 data bits, a second with 5 data bits; each has its
//            own serial line and shares clock, reset and configuration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx8;
    logic       rx5;
    logic       par_en;
    logic       par_typ;
    logic       stop2;
    logic [5:0] presc;

    logic [7:0] pdata8;
    logic       dv8, perr8, serr8, glitch8, busy8;
    logic [4:0] pdata5;
    logic       dv5, perr5, serr5, glitch5, busy5;

    always #5 clk = ~clk;

    uart_rx_core #(.DATA_WIDTH(8), .PRESCALE_W(6)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX_IN       (rx8),
        .Par_En      (par_en),
        .Par_Typ     (par_typ),
        .Stop2       (stop2),
        .Prescale    (presc),
        .P_DATA      (pdata8),
        .Data_Valid  (dv8),
        .par_err     (perr8),
        .stp_err     (serr8),
        .strt_glitch (glitch8),
        .busy        (busy8)
    );

    uart_rx_core #(.DATA_WIDTH(5), .PRESCALE_W(6)) u_dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX_IN       (rx5),
        .Par_En      (par_en),
        .Par_Typ     (par_typ),
        .Stop2       (stop2),
        .Prescale    (presc),
        .P_DATA      (pdata5),
        .Data_Valid  (dv5),
        .par_err     (perr5),
        .stp_err     (serr5),
        .strt_glitch (glitch5),
        .busy        (busy5)
    );

    // Cycle index: while the bench drives after a rising edge, cyc names
    // the current cycle; strobes are sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log
    logic [7:0] dv8_data[$];
    int         dv8_cyc[$];
    int         n_perr8 = 0, perr8_cyc = 0;
    int         n_serr8 = 0, serr8_cyc = 0;
    int         n_glitch8 = 0, glitch8_cyc = 0;
    logic       glitch8_busy = 1'b1;
    int         n_dv5 = 0, dv5_cyc = 0;
    logic [4:0] dv5_data = '0;
    int         n_perr5 = 0, n_serr5 = 0;

    always @(negedge clk) begin
        if (dv8) begin
            dv8_data.push_back(pdata8);
            dv8_cyc.push_back(cyc);
        end
        if (perr8)   begin n_perr8++;   perr8_cyc = cyc; end
        if (serr8)   begin n_serr8++;   serr8_cyc = cyc; end
        if (glitch8) begin n_glitch8++; glitch8_cyc = cyc; glitch8_busy = busy8; end
        if (dv5)     begin n_dv5++; dv5_cyc = cyc; dv5_data = pdata5; end
        if (perr5)   n_perr5++;
        if (serr5)   n_serr5++;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] q_data(input int idx);
        return (idx < dv8_data.size()) ? 32'(dv8_data[idx]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] q_cyc(input int idx);
        return (idx < dv8_cyc.size()) ? 32'(dv8_cyc[idx]) : 32'hFFFF_FFFF;
    endfunction

    // Hold a line at level v for n cycles; called just after a rising edge
    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rx8 = v;
        else            rx5 = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full frame; the last stop bit is held for last_len cycles
    task automatic send_frame(input int which, input logic [8:0] data, input int dw,
                              input logic has_par, input logic par_bit, input int nstop,
                              input logic stop_a, input logic stop_b, input int last_len,
                              input int p, output int t0);
        t0 = cyc;
        drive(which, 1'b0, p);
        for (int i = 0; i < dw; i++) drive(which, data[i], p);
        if (has_par) drive(which, par_bit, p);
        if (nstop == 2) begin
            drive(which, stop_a, p);
            drive(which, stop_b, last_len);
        end else begin
            drive(which, stop_a, last_len);
        end
    endtask

    int t0, t0b, base, sp, ss, sg;

    task automatic snap();
        base = dv8_data.size();
        sp   = n_perr8;
        ss   = n_serr8;
        sg   = n_glitch8;
    endtask

    logic [7:0] spike_byte;

    initial begin
        rst_n = 1'b0; rx8 = 1'b1; rx5 = 1'b1;
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; presc = 6'd8;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pdata8", 32'(pdata8), 32'h0);
        chk("rst_dv8",    32'(dv8),    32'h0);
        chk("rst_errs8",  32'({perr8, serr8, glitch8}), 32'h0);
        chk("rst_busy8",  32'(busy8),  32'h0);
        chk("rst_pdata5", 32'(pdata5), 32'h0);
        rst_n = 1'b1;
        drive(0, 1'b1, 4);

        // Basic 8N1, Prescale 8: 9 bits before the stop bit -> 9*8+4+3 = 79
        snap();
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8, 8, t0);
        drive(0, 1'b1, 10);
        chk("8n1_count", 32'(dv8_data.size() - base), 32'd1);
        chk("8n1_data",  q_data(base), 32'hA5);
        chk("8n1_lat",   q_cyc(base) - 32'(t0), 32'd79);
        chk("8n1_noerr", 32'(n_perr8 - sp + n_serr8 - ss + n_glitch8 - sg), 32'd0);

        // Odd parity, Prescale 16: 0x3C has four ones -> parity bit 1.
        // 10 bits before the stop bit -> 10*16+8+3 = 171
        par_en = 1'b1; par_typ = 1'b1; presc = 6'd16;
        snap();
        send_frame(0, 9'h03C, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1, 16, 16, t0);
        drive(0, 1'b1, 10);
        chk("odd_ok_count", 32'(dv8_data.size() - base), 32'd1);
        chk("odd_ok_data",  q_data(base), 32'h3C);
        chk("odd_ok_lat",   q_cyc(base) - 32'(t0), 32'd171);
        chk("odd_ok_perr",  32'(n_perr8 - sp), 32'd0);

        snap();
        send_frame(0, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1, 16, 16, t0);
        drive(0, 1'b1, 10);
        chk("odd_bad_perr",  32'(n_perr8 - sp), 32'd1);
        chk("odd_bad_lat",   32'(perr8_cyc - t0), 32'd171);
        chk("odd_bad_dv",    32'(dv8_data.size() - base), 32'd0);
        chk("odd_bad_serr",  32'(n_serr8 - ss), 32'd0);
        chk("odd_bad_pdata", 32'(pdata8), 32'h3C);

        // Start glitch: low 3 cycles at Prescale 8 -> strt_glitch at t0+7
        par_en = 1'b0; par_typ = 1'b0; presc = 6'd8;
        snap();
        t0 = cyc;
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 12);
        chk("glitch_count", 32'(n_glitch8 - sg), 32'd1);
        chk("glitch_lat",   32'(glitch8_cyc - t0), 32'd7);
        chk("glitch_busy",  32'(glitch8_busy), 32'd0);
        chk("glitch_dv",    32'(dv8_data.size() - base), 32'd0);

        // One-cycle low spike at the mid-bit sample of data bit 1 of 0x5A
        spike_byte = 8'h5A;
        snap();
        t0 = cyc;
        drive(0, 1'b0, 8);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                drive(0, 1'b1, 4);
                drive(0, 1'b0, 1);
                drive(0, 1'b1, 3);
            end else begin
                drive(0, spike_byte[i], 8);
            end
        end
        drive(0, 1'b1, 12);
        chk("spike_count", 32'(dv8_data.size() - base), 32'd1);
        chk("spike_data",  q_data(base), 32'h5A);
        chk("spike_lat",   q_cyc(base) - 32'(t0), 32'd79);

        // 8N2, Prescale 32, second stop low: 10 bits before it -> 10*32+16+3 = 339
        stop2 = 1'b1; presc = 6'd32;
        snap();
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 2, 1'b1, 1'b0, 32, 32, t0);
        drive(0, 1'b1, 10);
        chk("stop2_serr",  32'(n_serr8 - ss), 32'd1);
        chk("stop2_lat",   32'(serr8_cyc - t0), 32'd339);
        chk("stop2_perr",  32'(n_perr8 - sp), 32'd0);
        chk("stop2_dv",    32'(dv8_data.size() - base), 32'd0);
        chk("stop2_pdata", 32'(pdata8), 32'h5A);

        // Break: line stays low after the second stop bit
        snap();
        send_frame(0, 9'h042, 8, 1'b0, 1'b0, 2, 1'b1, 1'b0, 32, 32, t0);
        drive(0, 1'b0, 100);
        chk("break_serr",   32'(n_serr8 - ss), 32'd1);
        chk("break_busy",   32'(busy8), 32'd0);
        chk("break_glitch", 32'(n_glitch8 - sg), 32'd0);
        chk("break_dv",     32'(dv8_data.size() - base), 32'd0);
        drive(0, 1'b1, 5);
        snap();
        send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 2, 1'b1, 1'b1, 32, 32, t0);
        drive(0, 1'b1, 10);
        chk("after_break_data", q_data(base), 32'hC3);
        chk("after_break_lat",  q_cyc(base) - 32'(t0), 32'd339);
        chk("after_break_errs", 32'(n_serr8 - ss + n_perr8 - sp), 32'd0);

        // 5-bit instance, 5E2 at Prescale 8: 0x15 has three ones -> parity 1.
        // start + 5 data + parity + first stop = 8 bits -> 8*8+4+3 = 71
        par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b1; presc = 6'd8;
        send_frame(1, 9'h015, 5, 1'b1, 1'b1, 2, 1'b1, 1'b1, 8, 8, t0);
        drive(1, 1'b1, 8);
        chk("w5_count", 32'(n_dv5), 32'd1);
        chk("w5_data",  32'(dv5_data), 32'h15);
        chk("w5_lat",   32'(dv5_cyc - t0), 32'd71);
        chk("w5_errs",  32'(n_perr5 + n_serr5), 32'd0);

        // Back-to-back: second start right after the first final decision
        par_en = 1'b0; stop2 = 1'b0; presc = 6'd8;
        snap();
        send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 7, 8, t0);
        send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8, 8, t0b);
        drive(0, 1'b1, 6);
        chk("b2b_count", 32'(dv8_data.size() - base), 32'd2);
        chk("b2b_data0", q_data(base), 32'h00);
        chk("b2b_lat0",  q_cyc(base) - 32'(t0), 32'd79);
        chk("b2b_data1", q_data(base + 1), 32'hFF);
        chk("b2b_lat1",  q_cyc(base + 1) - 32'(t0b), 32'd79);
        chk("b2b_errs",  32'(n_serr8 - ss + n_glitch8 - sg), 32'd0);

        // Reset in the middle of data bit 2
        snap();
        drive(0, 1'b0, 8);
        drive(0, 1'b1, 8);
        drive(0, 1'b0, 8);
        drive(0, 1'b1, 4);
        chk("mid_busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pdata", 32'(pdata8), 32'h0);
        chk("mid_rst_busy",  32'(busy8), 32'd0);
        rx8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1'b1, 30);
        chk("mid_rst_nostrobe",
            32'(dv8_data.size() - base + n_serr8 - ss + n_perr8 - sp + n_glitch8 - sg), 32'd0);
        snap();
        send_frame(0, 9'h037, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8, 8, t0);
        drive(0, 1'b1, 10);
        chk("post_rst_data", q_data(base), 32'h37);
        chk("post_rst_lat",  q_cyc(base) - 32'(t0), 32'd79);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
